// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller_if
// Brief   : Hazard/stall control bundle between the pipeline and its controller.
// Rev     : 1.0
// ============================================================================
interface pipeline_hazard_controller_if;
    logic [1:0]  id_rs;
    logic [1:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [1:0]  ex_rd;
    logic        ex_mispredict;
    logic        d_mem_req;
    logic        d_cache_ready;
    logic        i_cache_ready;
    logic        halt_req;
    logic        pc_write;
    logic        if_id_write;
    logic        flush_if_id;
    logic        stall;
    logic        stall_mem;
    logic        bubble;
    logic [1:0]  state;
    logic        mem_timeout;
    logic [15:0] stall_count;
    logic [15:0] bubble_count;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_rd, ex_mispredict, d_mem_req, d_cache_ready, i_cache_ready, halt_req,
        input  pc_write, if_id_write, flush_if_id, stall, stall_mem, bubble,
               state, mem_timeout, stall_count, bubble_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
               ex_rd, ex_mispredict, d_mem_req, d_cache_ready, i_cache_ready, halt_req,
        output pc_write, if_id_write, flush_if_id, stall, stall_mem, bubble,
               state, mem_timeout, stall_count, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_hazard_controller
// Brief   : Stall/flush/bubble control for a 5-stage pipeline with D-cache waits.
// Rev     : 1.0
// ============================================================================
module pipeline_hazard_controller #(
    parameter int MEM_TIMEOUT = 255
) (
    input  wire logic                    clk,
    input  wire logic                    reset_n,
    pipeline_hazard_controller_if.slave  hz
);
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2,
        S_HALTED   = 2'd3
    } state_t;

    localparam logic [7:0]  c_timeout = 8'(MEM_TIMEOUT);
    localparam logic [7:0]  c_wait_max = 8'hFF;
    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_miss_pend;
    logic        r_halt_pend;
    logic        r_mem_timeout;
    logic [7:0]  r_wait_cnt;
    logic [15:0] r_stall_count;
    logic [15:0] r_bubble_count;

    logic        w_miss;
    logic        w_load_use;
    logic        w_miss_pend_eff;
    logic        w_halt_pend_eff;
    logic [7:0]  w_wait_inc;
    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_flush_if_id;
    logic        w_stall;
    logic        w_stall_mem;
    logic        w_bubble;

    assign w_miss     = hz.d_mem_req & ~hz.d_cache_ready;
    assign w_load_use = hz.ex_mem_read & hz.ex_reg_write &
                        ((hz.id_uses_rs & (hz.id_rs == hz.ex_rd)) |
                         (hz.id_uses_rt & (hz.id_rt == hz.ex_rd)));

    // A redirect or halt arriving on the very cycle the fill completes still counts.
    assign w_miss_pend_eff = r_miss_pend | hz.ex_mispredict;
    assign w_halt_pend_eff = r_halt_pend | hz.halt_req;
    assign w_wait_inc      = (r_wait_cnt == c_wait_max) ? r_wait_cnt : r_wait_cnt + 8'd1;

    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_flush_if_id = 1'b0;
        w_stall       = 1'b0;
        w_stall_mem   = 1'b0;
        w_bubble      = 1'b0;
        w_state_next  = r_state;
        case (r_state)
            S_RUN, S_FLUSH: begin
                if (w_miss) begin
                    w_stall_mem   = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                end else if ((r_state == S_RUN) && hz.ex_mispredict) begin
                    w_bubble      = 1'b1;
                    w_flush_if_id = 1'b1;
                end else if (((r_state == S_RUN) && w_load_use) || !hz.i_cache_ready) begin
                    // In FLUSH the EX slot holds a squashed instruction, so no load-use.
                    w_stall       = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                end
                if (hz.halt_req)
                    w_state_next = S_HALTED;
                else if (w_miss)
                    w_state_next = S_MEM_WAIT;
                else if (w_bubble)
                    w_state_next = S_FLUSH;
                else
                    w_state_next = S_RUN;
            end
            S_MEM_WAIT: begin
                if (!hz.d_cache_ready) begin
                    w_stall_mem   = 1'b1;
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                end else begin
                    if (w_miss_pend_eff) begin
                        w_bubble      = 1'b1;
                        w_flush_if_id = 1'b1;
                    end
                    if (w_halt_pend_eff)
                        w_state_next = S_HALTED;
                    else if (w_miss_pend_eff)
                        w_state_next = S_FLUSH;
                    else
                        w_state_next = S_RUN;
                end
            end
            default: begin
                w_stall       = 1'b1;
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
            end
        endcase
        if (!reset_n) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_flush_if_id = 1'b0;
            w_stall       = 1'b0;
            w_stall_mem   = 1'b0;
            w_bubble      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_RUN;
            r_miss_pend    <= 1'b0;
            r_halt_pend    <= 1'b0;
            r_mem_timeout  <= 1'b0;
            r_wait_cnt     <= 8'd0;
            r_stall_count  <= 16'd0;
            r_bubble_count <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_MEM_WAIT) begin
                if (hz.d_cache_ready) begin
                    r_miss_pend <= 1'b0;
                    r_halt_pend <= 1'b0;
                end else begin
                    if (hz.ex_mispredict)
                        r_miss_pend <= 1'b1;
                    if (hz.halt_req)
                        r_halt_pend <= 1'b1;
                end
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_timeout)
                    r_mem_timeout <= 1'b1;
            end else begin
                r_wait_cnt <= 8'd0;
                if (w_miss && hz.ex_mispredict && (r_state != S_HALTED))
                    r_miss_pend <= 1'b1;
            end
            if (!w_pc_write && (r_stall_count != c_cnt_max))
                r_stall_count <= r_stall_count + 16'd1;
            if (w_bubble && (r_bubble_count != c_cnt_max))
                r_bubble_count <= r_bubble_count + 16'd1;
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.if_id_write  = w_if_id_write;
    assign hz.flush_if_id  = w_flush_if_id;
    assign hz.stall        = w_stall;
    assign hz.stall_mem    = w_stall_mem;
    assign hz.bubble       = w_bubble;
    assign hz.state        = r_state;
    assign hz.mem_timeout  = r_mem_timeout;
    assign hz.stall_count  = r_stall_count;
    assign hz.bubble_count = r_bubble_count;
endmodule
`default_nettype wire
